// File: rtl/core_dataflow_ctrl_if.sv
// Bus bundle for core_dataflow_ctrl: SRAM-to-corelet steering signals and the OFIFO-to-psum-SRAM drain port.
// Handshake: drain_start is a one-cycle request taken only while drain_busy is low; ofifo_rd pops one row only when ofifo_valid is high.
interface core_dataflow_ctrl_if #(
    parameter int bw      = 4,
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
);
    logic                     mode;
    logic                     data_mode;
    logic                     xmem_rd;
    logic [bw*row-1:0]        q_act;
    logic [bw*col-1:0]        q_wt;
    logic [bw*row-1:0]        l0_in;
    logic                     l0_wr;
    logic [bw*col-1:0]        ififo_in;
    logic                     ififo_wr;
    logic                     drain_start;
    logic [addr_w:0]          drain_len;
    logic [addr_w-1:0]        drain_base;
    logic                     ofifo_valid;
    logic [col*psum_bw-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic                     CEN_omem;
    logic                     WEN_omem;
    logic [addr_w-1:0]        A_omem;
    logic [col*psum_bw-1:0]   D_omem;
    logic                     drain_busy;
    logic                     drain_done;

    modport master (
        output mode, data_mode, xmem_rd, q_act, q_wt,
        output drain_start, drain_len, drain_base, ofifo_valid, ofifo_out,
        input  l0_in, l0_wr, ififo_in, ififo_wr, ofifo_rd,
        input  CEN_omem, WEN_omem, A_omem, D_omem, drain_busy, drain_done
    );

    modport slave (
        input  mode, data_mode, xmem_rd, q_act, q_wt,
        input  drain_start, drain_len, drain_base, ofifo_valid, ofifo_out,
        output l0_in, l0_wr, ififo_in, ififo_wr, ofifo_rd,
        output CEN_omem, WEN_omem, A_omem, D_omem, drain_busy, drain_done
    );
endinterface

// File: rtl/core_dataflow_ctrl.sv
// Dataflow controller: steers SRAM Q to L0/IFIFO by mode and drains OFIFO rows into the psum SRAM.
// Optional macro CORE_DRAIN_RELU_EN clamps negative psum lanes to zero at capture.
module core_dataflow_ctrl #(
    parameter int bw      = 4,
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    core_dataflow_ctrl_if.slave    bus,
    output logic [2:0]             dbg_drain_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } drain_state_t;

    drain_state_t             state_q, state_d;
    logic                     rd_q, rd_d;
    logic [bw*row-1:0]        l0_in_q, l0_in_d;
    logic                     l0_wr_q, l0_wr_d;
    logic [bw*col-1:0]        ififo_in_q, ififo_in_d;
    logic                     ififo_wr_q, ififo_wr_d;
    logic [addr_w:0]          cnt_q, cnt_d;
    logic [addr_w-1:0]        addr_q, addr_d;
    logic                     cen_q, cen_d;
    logic                     wen_q, wen_d;
    logic [addr_w-1:0]        a_q, a_d;
    logic [col*psum_bw-1:0]   d_q, d_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [col*psum_bw-1:0]   cap_row;

    // SRAM Q lags xmem_rd by one cycle, so rd_q marks the cycle in which Q is sampled.
    always_comb begin
        rd_d       = bus.xmem_rd;
        l0_in_d    = l0_in_q;
        ififo_in_d = ififo_in_q;
        l0_wr_d    = rd_q;
        ififo_wr_d = rd_q & ~bus.mode;
        if (rd_q) begin
            if (bus.mode) begin
                l0_in_d = bus.data_mode ? bus.q_wt : bus.q_act;
            end else begin
                l0_in_d    = bus.q_act;
                ififo_in_d = bus.q_wt;
            end
        end
    end

    always_comb begin
        cap_row = bus.ofifo_out;
`ifdef CORE_DRAIN_RELU_EN
        for (int i = 0; i < col; i++) begin
            if (bus.ofifo_out[i*psum_bw+psum_bw-1]) cap_row[i*psum_bw +: psum_bw] = '0;
        end
`endif
    end

    // SRAM strobes are precomputed on the CAP->WR edge so they are flops aligned with WR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        a_d     = a_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (bus.drain_start) begin
                    cnt_d   = bus.drain_len;
                    addr_d  = bus.drain_base;
                    state_d = (bus.drain_len == '0) ? DONE : POP;
                end
            end
            POP: begin
                if (bus.ofifo_valid) state_d = CAP;
            end
            CAP: begin
                d_d     = cap_row;
                a_d     = addr_q;
                cen_d   = 1'b0;
                wen_d   = 1'b0;
                state_d = WR;
            end
            WR: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == {{addr_w{1'b0}}, 1'b1}) ? DONE : POP;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            l0_in_q    <= '0;
            l0_wr_q    <= 1'b0;
            ififo_in_q <= '0;
            ififo_wr_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            cen_q      <= 1'b1;
            wen_q      <= 1'b1;
            a_q        <= '0;
            d_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            l0_in_q    <= l0_in_d;
            l0_wr_q    <= l0_wr_d;
            ififo_in_q <= ififo_in_d;
            ififo_wr_q <= ififo_wr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            a_q        <= a_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The pop must react to ofifo_valid in the same cycle, so it is a decode of the state flop.
    assign bus.ofifo_rd    = (state_q == POP) & bus.ofifo_valid;
    assign bus.l0_in       = l0_in_q;
    assign bus.l0_wr       = l0_wr_q;
    assign bus.ififo_in    = ififo_in_q;
    assign bus.ififo_wr    = ififo_wr_q;
    assign bus.CEN_omem    = cen_q;
    assign bus.WEN_omem    = wen_q;
    assign bus.A_omem      = a_q;
    assign bus.D_omem      = d_q;
    assign bus.drain_busy  = busy_q;
    assign bus.drain_done  = done_q;
    assign dbg_drain_state = state_q;
endmodule

// File: tb/tb_core_dataflow_ctrl.sv
// Bench for core_dataflow_ctrl: random steering and drain traffic against a queue-based reference.
// Build with CORE_DRAIN_RELU_EN defined to check the ReLU variant.
module tb_core_dataflow_ctrl;
  localparam int BW = 4, ROW = 8, COL = 8, PSUM_BW = 16, ADDR_W = 11;
  localparam int DW = BW*ROW;
  localparam int OW = COL*PSUM_BW;
  localparam int SW = 2*DW + 1;
  localparam int WW = ADDR_W + OW;
  localparam int DEPTH = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg_state;

  core_dataflow_ctrl_if #(.bw(BW), .row(ROW), .col(COL), .psum_bw(PSUM_BW), .addr_w(ADDR_W)) bus ();

  core_dataflow_ctrl #(.bw(BW), .row(ROW), .col(COL), .psum_bw(PSUM_BW), .addr_w(ADDR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_drain_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [SW-1:0] steer_q[$];      // {ififo_wr, l0_in, ififo_in}
  logic [WW-1:0] wr_q[$];         // {addr, data}
  int            done_q[$];       // drain length per expected done
  logic [OW-1:0] ofifo_q[$];      // rows the OFIFO model holds
  logic [DW-1:0] mdl_fi = '0;
  logic [DW-1:0] mon_l0 = '0, mon_fi = '0;
  bit            prev_rd = 1'b0;
  bit            steer_en = 1'b0, dir_valid = 1'b0;
  bit            dir_rd, dir_m, dir_dm;
  logic [DW-1:0] dir_qa, dir_qw;
  bit            stall = 1'b0, stall_rand = 1'b0, pend_valid = 1'b0;
  logic [OW-1:0] ofifo_pend;
  bit            drain_active = 1'b0, chk_idle_next = 1'b0;
  int            start_cyc = 0, last_wr_cyc = 0, done_cyc = 0, stall_rd = 0;
  logic [OW-1:0] last_d;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] relu_model(input logic [OW-1:0] r);
    logic [OW-1:0] o;
    o = r;
`ifdef CORE_DRAIN_RELU_EN
    for (int i = 0; i < COL; i++)
      if ($signed(r[i*PSUM_BW +: PSUM_BW]) < 0) o[i*PSUM_BW +: PSUM_BW] = '0;
`endif
    return o;
  endfunction

  // ---------------- steering driver ----------------
  // Data for a read issued last cycle is on Q now; its expected write is pushed here.
  task automatic drive_steer(input bit rd, input bit m, input bit dm, input logic [DW-1:0] qa, input logic [DW-1:0] qw);
    logic [DW-1:0] l0;
    bus.xmem_rd = rd; bus.mode = m; bus.data_mode = dm; bus.q_act = qa; bus.q_wt = qw;
    if (prev_rd) begin
      if (m) begin
        l0 = dm ? qw : qa;
        steer_q.push_back({1'b0, l0, mdl_fi});
      end else begin
        mdl_fi = qw;
        steer_q.push_back({1'b1, qa, qw});
      end
    end
    prev_rd = rd;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (dir_valid) begin
        drive_steer(dir_rd, dir_m, dir_dm, dir_qa, dir_qw);
        dir_valid = 1'b0;
      end else if (steer_en) begin
        drive_steer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
      end else begin
        drive_steer(1'b0, bus.mode, bus.data_mode, DW'($urandom), DW'($urandom));
      end
    end
  end

  // ---------------- OFIFO model ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (pend_valid) begin
        bus.ofifo_out = ofifo_pend;
        pend_valid = 1'b0;
      end else begin
        bus.ofifo_out = {4{32'($urandom)}};
      end
      bus.ofifo_valid = (ofifo_q.size() > 0) && !stall;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (stall_rand) stall = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [SW-1:0] e;
    if (bus.l0_wr) begin
      if (steer_q.size() == 0) begin
        check("steer_unexpected_wr", 1'b1, 1'b0);
      end else begin
        e = steer_q.pop_front();
        check("l0_in", bus.l0_in, e[SW-2 -: DW]);
        check("ififo_wr", bus.ififo_wr, e[SW-1]);
        check("ififo_in", bus.ififo_in, e[DW-1:0]);
        mon_l0 = e[SW-2 -: DW];
        mon_fi = e[DW-1:0];
      end
    end else begin
      check("ififo_wr_idle", bus.ififo_wr, 1'b0);
      check("l0_hold", bus.l0_in, mon_l0);
      check("ififo_hold", bus.ififo_in, mon_fi);
    end
  end

  always @(negedge clk) begin
    logic [WW-1:0] w;
    int len;
    check("cen_wen_pair", bus.WEN_omem, bus.CEN_omem);
    if (bus.ofifo_rd) begin
      if (stall) stall_rd++;
      check("pop_needs_valid", bus.ofifo_valid, 1'b1);
      if (ofifo_q.size() == 0) check("pop_empty_fifo", 1'b1, 1'b0);
      else begin
        ofifo_pend = ofifo_q.pop_front();
        pend_valid = 1'b1;
      end
    end
    if (bus.CEN_omem == 1'b0) begin
      last_wr_cyc = cyc;
      last_d = bus.D_omem;
      if (wr_q.size() == 0) check("unexpected_write", 1'b1, 1'b0);
      else begin
        w = wr_q.pop_front();
        check("wr_addr", bus.A_omem, w[WW-1 -: ADDR_W]);
        check("wr_data", bus.D_omem, w[OW-1:0]);
      end
    end
    if (bus.drain_done) begin
      check("busy_in_done", bus.drain_busy, 1'b1);
      if (done_q.size() == 0) check("unexpected_done", 1'b1, 1'b0);
      else begin
        len = done_q.pop_front();
        check("writes_before_done", wr_q.size(), 0);
        if (len == 0) check("done_latency_zero", cyc, start_cyc + 1);
        else check("done_after_last_wr", cyc, last_wr_cyc + 1);
        done_cyc = cyc;
        drain_active = 1'b0;
        chk_idle_next = 1'b1;
      end
    end else if (chk_idle_next) begin
      check("busy_drops", bus.drain_busy, 1'b0);
      chk_idle_next = 1'b0;
    end
  end

  // ---------------- drain driver ----------------
  task automatic start_drain(input int len, input int base, input bit accept, input bit relu_row);
    logic [OW-1:0] r;
    @(negedge clk);
    if (accept) begin
      for (int i = 0; i < len; i++) begin
        for (int l = 0; l < COL; l++) r[l*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
        if (relu_row && i == 0) begin
          r[15:0] = 16'hFFF0;
          r[31:16] = 16'h0010;
        end
        ofifo_q.push_back(r);
        wr_q.push_back({ADDR_W'((base + i) % DEPTH), relu_model(r)});
      end
      done_q.push_back(len);
      start_cyc = cyc;
      drain_active = 1'b1;
    end
    bus.drain_start = 1'b1;
    bus.drain_len = (ADDR_W+1)'(len);
    bus.drain_base = ADDR_W'(base);
    @(negedge clk);
    bus.drain_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 400 && drain_active; n++) @(negedge clk);
    if (drain_active) begin
      check("drain_timeout", 1'b1, 1'b0);
      drain_active = 1'b0;
      wr_q.delete(); done_q.delete(); ofifo_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic steer_dir(input bit rd, input bit m, input bit dm, input logic [DW-1:0] qa, input logic [DW-1:0] qw);
    @(negedge clk);
    dir_rd = rd; dir_m = m; dir_dm = dm; dir_qa = qa; dir_qw = qw;
    dir_valid = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    bus.mode = 1'b1; bus.data_mode = 1'b0; bus.xmem_rd = 1'b0;
    bus.q_act = '0; bus.q_wt = '0;
    bus.drain_start = 1'b0; bus.drain_len = '0; bus.drain_base = '0;
    bus.ofifo_valid = 1'b0; bus.ofifo_out = '0;
    repeat (3) @(negedge clk);
    check("rst_l0_in", bus.l0_in, 0);
    check("rst_l0_wr", bus.l0_wr, 0);
    check("rst_ififo_in", bus.ififo_in, 0);
    check("rst_cen", bus.CEN_omem, 1);
    check("rst_wen", bus.WEN_omem, 1);
    check("rst_a", bus.A_omem, 0);
    check("rst_d", bus.D_omem, 0);
    check("rst_busy", bus.drain_busy, 0);
    check("rst_done", bus.drain_done, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // WS: weights to L0
    steer_dir(1'b1, 1'b1, 1'b1, 32'h0BAD_0BAD, 32'h0);
    steer_dir(1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD, 32'hA5A5_1234);
    repeat (2) @(negedge clk);
    check("ws_l0_in", bus.l0_in, 32'hA5A5_1234);
    check("ws_l0_wr", bus.l0_wr, 1);
    check("ws_ififo_wr", bus.ififo_wr, 0);
    // OS: both paths
    steer_dir(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    steer_dir(1'b0, 1'b0, 1'b0, 32'h1111_2222, 32'h3333_4444);
    repeat (2) @(negedge clk);
    check("os_l0_in", bus.l0_in, 32'h1111_2222);
    check("os_ififo_in", bus.ififo_in, 32'h3333_4444);
    check("os_strobes", {bus.l0_wr, bus.ififo_wr}, 2'b11);

    // basic drain
    start_drain(3, 5, 1'b1, 1'b0);
    wait_done();
    check("basic_latency", done_cyc - start_cyc, 10);

    // stall, wrap and ignored restart
    stall_rd = 0;
    stall = 1'b1;
    start_drain(2, 2047, 1'b1, 1'b0);
    check("stall_in_pop", dbg_state, 1);
    start_drain(5, 0, 1'b0, 1'b0);
    @(negedge clk);
    stall = 1'b0;
    check("stall_no_pop", stall_rd, 0);
    wait_done();

    // zero length and ReLU lanes
    start_drain(0, 33, 1'b1, 1'b0);
    wait_done();
    start_drain(1, 200, 1'b1, 1'b1);
    wait_done();
`ifdef CORE_DRAIN_RELU_EN
    check("relu_neg_lane", last_d[15:0], 16'h0000);
`else
    check("relu_neg_lane", last_d[15:0], 16'hFFF0);
`endif
    check("relu_pos_lane", last_d[31:16], 16'h0010);

    // random concurrent traffic
    steer_en = 1'b1;
    stall_rand = 1'b1;
    for (int k = 0; k < 12; k++) begin
      start_drain($urandom_range(0, 6), $urandom_range(2030, 2047), 1'b1, 1'b0);
      wait_done();
    end
    stall_rand = 1'b0;
    stall = 1'b0;
    steer_en = 1'b0;
    repeat (5) @(negedge clk);
    check("steer_drained", steer_q.size(), 0);

    // reset during WR
    start_drain(3, 100, 1'b1, 1'b0);
    for (int n = 0; n < 50 && bus.CEN_omem; n++) @(negedge clk);
    check("reached_wr", bus.CEN_omem, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_cen", bus.CEN_omem, 1);
    check("mid_rst_wen", bus.WEN_omem, 1);
    check("mid_rst_busy", bus.drain_busy, 0);
    check("mid_rst_done", bus.drain_done, 0);
    check("mid_rst_d", bus.D_omem, 0);
    wr_q.delete(); done_q.delete(); ofifo_q.delete();
    pend_valid = 1'b0; drain_active = 1'b0; chk_idle_next = 1'b0;
    mon_l0 = '0; mon_fi = '0; mdl_fi = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_state", dbg_state, 0);
    start_drain(2, 7, 1'b1, 1'b0);
    wait_done();
    check("final_writes", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
